neg_mul_seq: RTL



---
 rtl/neg_mul_seq_if.sv | 24 ++
 rtl/neg_mul_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/neg_mul_seq_if.sv
// Handshake and data bundle for the sequential signed multiplier.
// master = producer/consumer side, slave = the multiplier itself.
interface neg_mul_seq_if #(
  parameter int unsigned W = 56
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din1;
  logic [W-1:0] din2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         ovf;

  modport master (
    output in_valid, din1, din2, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din1, din2, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/neg_mul_seq.sv
// Sequential signed fixed-point multiplier: sign-magnitude conversion at
// acceptance, one-bit-per-cycle shift-add over W cycles, then sign restore,
// FRAC scaling (magnitude truncated toward zero) and saturation to W bits.
module neg_mul_seq #(
  parameter int unsigned W    = 56,
  parameter int unsigned FRAC = 0
) (
  input logic         clk,
  input logic         rst,
  neg_mul_seq_if.slave bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST     = CW'(W - 1);
  localparam logic [W-1:0]  POS_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  NEG_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_neg;
  logic           r_zero;
  logic [W-1:0]   r_dout;
  logic           r_ovf;

  logic [W-1:0]   w_abs1;
  logic [W-1:0]   w_abs2;
  logic [2*W-1:0] w_acc_next;
  logic [2*W-1:0] w_m;
  logic           w_hi_any;
  logic           w_pos_ovf;
  logic           w_neg_ovf;
  logic [W-1:0]   w_dout_fmt;
  logic           w_ovf_fmt;
  logic           w_in_ready;
  logic           w_out_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, W iterations in CALC, hold in DONE until taken.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)    w_state_next = CALC;
      CALC:    if (r_cnt == LAST)   w_state_next = DONE;
      DONE:    if (bus.out_ready)   w_state_next = IDLE;
      default:                      w_state_next = IDLE;
    endcase
  end

  // Handshake outputs derived only from state.
  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == DONE);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.dout      = r_dout;
  assign bus.ovf       = r_ovf;

  // Operand magnitudes; |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
  always_comb begin
    w_abs1 = bus.din1[W-1] ? (~bus.din1 + W'(1)) : bus.din1;
    w_abs2 = bus.din2[W-1] ? (~bus.din2 + W'(1)) : bus.din2;
  end

  // Shift-add step and result formatting from the post-iteration accumulator.
  // The multiplicand is pre-shifted and the multiplier consumed LSB first, which
  // is the same as adding mag1<<cnt when mag2[cnt] is set, without a barrel shifter.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_m        = w_acc_next >> FRAC;
    w_hi_any   = |w_m[2*W-1:W];
    w_pos_ovf  = w_hi_any | w_m[W-1];
    w_neg_ovf  = w_hi_any | (w_m[W-1] & (|w_m[W-2:0]));
    if (r_zero) begin
      w_dout_fmt = '0;
      w_ovf_fmt  = 1'b0;
    end else if (!r_neg) begin
      w_dout_fmt = w_pos_ovf ? POS_MAX : w_m[W-1:0];
      w_ovf_fmt  = w_pos_ovf;
    end else begin
      w_dout_fmt = w_neg_ovf ? NEG_MIN : (~w_m[W-1:0] + W'(1));
      w_ovf_fmt  = w_neg_ovf;
    end
  end

  // Datapath registers: capture at acceptance, iterate in CALC, latch result on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= {{W{1'b0}}, w_abs1};
            r_mplier <= w_abs2;
            r_neg    <= bus.din1[W-1] ^ bus.din2[W-1];
            r_zero   <= (bus.din1 == '0) || (bus.din2 == '0);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_dout <= w_dout_fmt;
            r_ovf  <= w_ovf_fmt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
